// File: rtl/flags_pkg.sv
// Shared types for the ALU flag register unit: operation and condition-code
// enums, the packed flag bundle and the per-operation flag mask table.
package flags_pkg;

    localparam int NUM_OPS_DEFAULT = 12;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_ASR = 4'd8,
        OP_ROL = 4'd9,
        OP_ROR = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } flag_t;

    localparam flag_t MASK_CVZ = 4'b1011;
    localparam flag_t MASK_ALL = 4'b1111;
    localparam flag_t MASK_Z   = 4'b0001;

    // Full 16-entry table so any 4-bit op index is defined; slots past OP_MUL only keep Z
    localparam flag_t FLAG_MASK [16] = '{
        MASK_CVZ, MASK_ALL, MASK_Z,   MASK_Z,
        MASK_Z,   MASK_Z,   MASK_Z,   MASK_Z,
        MASK_Z,   MASK_Z,   MASK_Z,   MASK_CVZ,
        MASK_Z,   MASK_Z,   MASK_Z,   MASK_Z
    };

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic flag_t flag_mask(input logic [3:0] op);
        return FLAG_MASK[op];
    endfunction

endpackage

// File: rtl/flags_cond_eval.sv
// Purely combinational condition-code evaluator over a C/N/V/Z flag bundle,
// shared by the flag register unit and any branch logic.
module flags_cond_eval
    import flags_pkg::*;
(
    input  flag_t      i_flags,
    input  logic [3:0] i_condSel,
    output logic       o_condTrue
);

    always_comb begin
        o_condTrue = 1'b0;
        case (cond_e'(i_condSel))
            COND_EQ: o_condTrue = i_flags.z;
            COND_NE: o_condTrue = !i_flags.z;
            COND_CS: o_condTrue = i_flags.c;
            COND_CC: o_condTrue = !i_flags.c;
            COND_MI: o_condTrue = i_flags.n;
            COND_PL: o_condTrue = !i_flags.n;
            COND_VS: o_condTrue = i_flags.v;
            COND_VC: o_condTrue = !i_flags.v;
            COND_HI: o_condTrue = i_flags.c & !i_flags.z;
            COND_LS: o_condTrue = !i_flags.c | i_flags.z;
            COND_GE: o_condTrue = (i_flags.n == i_flags.v);
            COND_LT: o_condTrue = (i_flags.n != i_flags.v);
            COND_GT: o_condTrue = !i_flags.z & (i_flags.n == i_flags.v);
            COND_LE: o_condTrue = i_flags.z | (i_flags.n != i_flags.v);
            COND_AL: o_condTrue = 1'b1;
            COND_NV: o_condTrue = 1'b0;
            default: o_condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_reg_unit.sv
// Registered ALU flag selector with sticky C/V and condition evaluation.
// Define FLAGS_OV_COUNT_EN to build the saturating overflow event counter.
module flags_reg_unit
    import flags_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEFAULT,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [OP_W-1:0]    operation,
    input  logic [NUM_OPS-1:0] inFlagC,
    input  logic [NUM_OPS-1:0] inFlagN,
    input  logic [NUM_OPS-1:0] inFlagV,
    input  logic [NUM_OPS-1:0] inFlagZ,
    input  logic               sticky_clr,
    input  logic [3:0]         cond_sel,
    output logic               out_valid,
    output logic               outFlagC,
    output logic               outFlagN,
    output logic               outFlagV,
    output logic               outFlagZ,
    output logic               stickyC,
    output logic               stickyV,
    output logic               illegal_op,
    output logic               cond_true,
    output logic [CNT_W-1:0]   ov_count
);

    logic  w_legal;
    flag_t w_mask;
    flag_t w_cand;
    flag_t w_new;
    flag_t r_flags;
    logic  r_valid;
    logic  r_illegal;
    logic  r_stickyC;
    logic  r_stickyV;

    assign w_legal = (int'(operation) < NUM_OPS);

    always_comb begin
        w_mask = MASK_Z;
        if (int'(operation) < 16) begin
            w_mask = flag_mask(4'(operation));
        end
    end

    always_comb begin
        w_cand = '0;
        if (w_legal) begin
            w_cand.c = inFlagC[operation];
            w_cand.n = inFlagN[operation];
            w_cand.v = inFlagV[operation];
            w_cand.z = inFlagZ[operation];
        end
    end

    // Illegal ops yield all-zero flags, which also leaves the sticky bits alone
    assign w_new = w_legal ? (w_cand & w_mask) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags   <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_stickyC <= 1'b0;
            r_stickyV <= 1'b0;
        end else begin
            r_valid   <= in_valid;
            r_illegal <= in_valid & !w_legal;
            if (in_valid) begin
                r_flags <= w_new;
            end
            r_stickyC <= (r_stickyC & !sticky_clr) | (in_valid & w_new.c);
            r_stickyV <= (r_stickyV & !sticky_clr) | (in_valid & w_new.v);
        end
    end

`ifdef FLAGS_OV_COUNT_EN
    logic [CNT_W-1:0] r_ovCount;
    logic             w_ovInc;

    assign w_ovInc = in_valid & w_new.v;

    // An overflow in the clearing cycle restarts the count at one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovCount <= '0;
        end else if (w_ovInc) begin
            if (sticky_clr) begin
                r_ovCount <= CNT_W'(1);
            end else if (!(&r_ovCount)) begin
                r_ovCount <= r_ovCount + CNT_W'(1);
            end
        end else if (sticky_clr) begin
            r_ovCount <= '0;
        end
    end

    assign ov_count = r_ovCount;
`else
    assign ov_count = '0;
`endif

    flags_cond_eval u_condEval (
        .i_flags    (r_flags),
        .i_condSel  (cond_sel),
        .o_condTrue (cond_true)
    );

    assign out_valid  = r_valid;
    assign illegal_op = r_illegal;
    assign outFlagC   = r_flags.c;
    assign outFlagN   = r_flags.n;
    assign outFlagV   = r_flags.v;
    assign outFlagZ   = r_flags.z;
    assign stickyC    = r_stickyC;
    assign stickyV    = r_stickyV;

endmodule

// File: tb/tb_flags_reg_unit.sv
// Scoreboard bench for flags_reg_unit: directed scenarios plus random traffic
// checked against a behavioural flag model kept in the bench.
module tb_flags_reg_unit;

    localparam int NUM_OPS = 12;
    localparam int OP_W    = 4;
    localparam int CNT_W   = 8;
    localparam int OV_MAX  = 255;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [OP_W-1:0]    operation;
    logic [NUM_OPS-1:0] inFlagC;
    logic [NUM_OPS-1:0] inFlagN;
    logic [NUM_OPS-1:0] inFlagV;
    logic [NUM_OPS-1:0] inFlagZ;
    logic               sticky_clr;
    logic [3:0]         cond_sel;
    logic               out_valid;
    logic               outFlagC;
    logic               outFlagN;
    logic               outFlagV;
    logic               outFlagZ;
    logic               stickyC;
    logic               stickyV;
    logic               illegal_op;
    logic               cond_true;
    logic [CNT_W-1:0]   ov_count;

    typedef struct {
        bit c;
        bit n;
        bit v;
        bit z;
        bit illegal;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   pulsesExpected = 0;
    int   pulsesSeen = 0;

    bit mC, mN, mV, mZ, mSC, mSV, mValid, mIllegal;
    int mOv;

    flags_reg_unit #(
        .NUM_OPS (NUM_OPS),
        .OP_W    (OP_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .operation  (operation),
        .inFlagC    (inFlagC),
        .inFlagN    (inFlagN),
        .inFlagV    (inFlagV),
        .inFlagZ    (inFlagZ),
        .sticky_clr (sticky_clr),
        .cond_sel   (cond_sel),
        .out_valid  (out_valid),
        .outFlagC   (outFlagC),
        .outFlagN   (outFlagN),
        .outFlagV   (outFlagV),
        .outFlagZ   (outFlagZ),
        .stickyC    (stickyC),
        .stickyV    (stickyV),
        .illegal_op (illegal_op),
        .cond_true  (cond_true),
        .ov_count   (ov_count)
    );

    always #5 clk = ~clk;

    // Meaningful flags per operation, as {c,n,v,z}
    function automatic bit [3:0] maskOf(int op);
        if (op == 1) return 4'b1111;
        if (op == 0 || op == 11) return 4'b1011;
        if (op < NUM_OPS) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic bit condOf(int sel, bit c, bit n, bit v, bit z);
        case (sel)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model, then checks state after the edge
    task automatic applyStimulus(bit r, bit valid, int op, logic [11:0] fc, logic [11:0] fn,
                                 logic [11:0] fv, logic [11:0] fz, bit clr, int cs);
        bit [3:0] mk;
        exp_t     e;
        rst        = r;
        in_valid   = valid;
        operation  = op[3:0];
        inFlagC    = fc;
        inFlagN    = fn;
        inFlagV    = fv;
        inFlagZ    = fz;
        sticky_clr = clr;
        cond_sel   = cs[3:0];

        if (r) begin
            {mC, mN, mV, mZ, mSC, mSV, mValid, mIllegal} = '0;
            mOv = 0;
        end else if (valid) begin
            mk = maskOf(op);
            if (op < NUM_OPS) begin
                mC = fc[op] & mk[3];
                mN = fn[op] & mk[2];
                mV = fv[op] & mk[1];
                mZ = fz[op] & mk[0];
            end else begin
                {mC, mN, mV, mZ} = '0;
            end
            mIllegal = (op >= NUM_OPS);
            mValid   = 1'b1;
            mSC      = (clr ? 1'b0 : mSC) | mC;
            mSV      = (clr ? 1'b0 : mSV) | mV;
`ifdef FLAGS_OV_COUNT_EN
            if (mV) mOv = clr ? 1 : ((mOv < OV_MAX) ? mOv + 1 : OV_MAX);
            else if (clr) mOv = 0;
`endif
            e.c = mC;
            e.n = mN;
            e.v = mV;
            e.z = mZ;
            e.illegal = mIllegal;
            expQ.push_back(e);
            pulsesExpected++;
        end else begin
            mValid   = 1'b0;
            mIllegal = 1'b0;
            if (clr) begin
                mSC = 1'b0;
                mSV = 1'b0;
                mOv = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid", int'(out_valid), int'(mValid));
        checkOutput("illegal_op", int'(illegal_op), int'(mIllegal));
        checkOutput("flags_cnvz", int'({outFlagC, outFlagN, outFlagV, outFlagZ}),
                    int'({mC, mN, mV, mZ}));
        checkOutput("stickyC", int'(stickyC), int'(mSC));
        checkOutput("stickyV", int'(stickyV), int'(mSV));
        checkOutput("ov_count", int'(ov_count), mOv);
        checkOutput($sformatf("cond_true_sel%0d", cs), int'(cond_true),
                    int'(condOf(cs, mC, mN, mV, mZ)));
    endtask

    // Monitor: every out_valid pulse retires one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            pulsesSeen++;
            if (expQ.size() == 0) begin
                checkOutput("mon_unexpected_valid", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("mon_flagC", int'(outFlagC), int'(e.c));
                checkOutput("mon_flagN", int'(outFlagN), int'(e.n));
                checkOutput("mon_flagV", int'(outFlagV), int'(e.v));
                checkOutput("mon_flagZ", int'(outFlagZ), int'(e.z));
                checkOutput("mon_illegal", int'(illegal_op), int'(e.illegal));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rc, rn, rv, rz;
        mOv = 0;

        // Reset, including a reset cycle that also carries an op
        applyStimulus(1, 0, 0, '0, '0, '0, '0, 0, 0);
        applyStimulus(1, 1, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 1, 0);

        // op1 with N set, Z cleared only at index 1
        applyStimulus(0, 1, 1, 12'h000, 12'h002, 12'h000, 12'hFFD, 0, 4);
        applyStimulus(0, 0, 0, '0, '0, '0, '0, 0, 5);

        // op2 with every candidate set: only Z survives
        applyStimulus(0, 1, 2, 12'h004, 12'h004, 12'h004, 12'h004, 0, 0);

        // Sticky V survives a later V=0 op, then clears
        applyStimulus(0, 1, 0, 12'h000, 12'h000, 12'h001, 12'h000, 0, 6);
        applyStimulus(0, 1, 0, 12'h000, 12'h000, 12'hFFE, 12'h000, 0, 7);
        applyStimulus(0, 0, 0, '0, '0, '0, '0, 1, 6);

        // Set beats a simultaneous clear
        applyStimulus(0, 1, 11, 12'h800, 12'h000, 12'h000, 12'h000, 1, 2);

        // Illegal op: flags zero, sticky untouched
        applyStimulus(0, 1, 13, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0);

        // N=1, V=0, Z=0 then sweep GE/LT/GT/LE
        applyStimulus(0, 1, 1, 12'h000, 12'h002, 12'h000, 12'h000, 0, 10);
        for (int s = 11; s <= 13; s++) begin
            applyStimulus(0, 0, 0, '0, '0, '0, '0, 0, s);
        end

        // Reset mid-stream with a pending op
        applyStimulus(1, 1, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0);
        applyStimulus(0, 0, 0, '0, '0, '0, '0, 0, 1);

`ifdef FLAGS_OV_COUNT_EN
        // Counter saturation
        for (int k = 0; k < 300; k++) begin
            applyStimulus(0, 1, 0, '0, '0, 12'hFFF, '0, 0, 6);
        end
        applyStimulus(0, 1, 0, '0, '0, 12'hFFF, '0, 1, 6);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rc = 12'($urandom());
            rn = 12'($urandom());
            rv = 12'($urandom());
            rz = 12'($urandom());
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                          int'($urandom_range(0, 15)), rc, rn, rv, rz,
                          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
        end

        applyStimulus(0, 0, 0, '0, '0, '0, '0, 0, 14);
        checkOutput("queue_empty", expQ.size(), 0);
        checkOutput("pulse_count", pulsesSeen, pulsesExpected);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
